// File: rtl/packet_pkg.sv
// Shared switch constants and the ingress packet layout.
// The 2-bit class field is named pkt_type because `type` is a reserved word.
package packet_pkg;
    localparam int NUM_PORTS  = 4;
    localparam int ADDR_WIDTH = 4;
    localparam int PKT_WIDTH  = 16;

    typedef struct packed {
        logic [ADDR_WIDTH-1:0] dst_mask;
        logic [1:0]            src;
        logic [1:0]            pkt_type;
        logic [7:0]            payload;
    } packet_t;
endpackage

// File: rtl/sync_fifo.sv
// Single-clock FIFO with wrap-bit pointers and a combinational head read.
// Writes to a full FIFO and reads from an empty one are ignored.
module sync_fifo #(
    parameter int WIDTH = 16,
    parameter int DEPTH = 4
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             wr_en,
    input  logic [WIDTH-1:0] wr_data,
    input  logic             rd_en,
    output logic [WIDTH-1:0] rd_data,
    output logic             full,
    output logic             empty
);
    localparam int AW = $clog2(DEPTH);
    localparam int PW = AW + 1;

    logic [PW-1:0]    wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]    rd_ptr_q, rd_ptr_d;
    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [WIDTH-1:0] mem_d [DEPTH];
    logic             do_wr, do_rd;

    // Same address with differing wrap bits means the writer lapped the reader.
    assign full    = (wr_ptr_q[AW-1:0] == rd_ptr_q[AW-1:0]) && (wr_ptr_q[AW] != rd_ptr_q[AW]);
    assign empty   = (wr_ptr_q == rd_ptr_q);
    assign rd_data = mem_q[rd_ptr_q[AW-1:0]];
    assign do_wr   = wr_en && !full;
    assign do_rd   = rd_en && !empty;

    always_comb begin
        wr_ptr_d = wr_ptr_q;
        rd_ptr_d = rd_ptr_q;
        mem_d    = mem_q;
        if (do_wr) begin
            mem_d[wr_ptr_q[AW-1:0]] = wr_data;
            wr_ptr_d                = wr_ptr_q + PW'(1);
        end
        if (do_rd) begin
            rd_ptr_d = rd_ptr_q + PW'(1);
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
        end
    end

    // Storage needs no reset: it is only observed behind a non-empty pointer pair.
    always_ff @(posedge clk) begin
        mem_q <= mem_d;
    end
endmodule

// File: rtl/input_port_buffer.sv
// Per-port ingress queue in front of the switch arbiter: filters zero-destination
// packets, presents the head request, and registers the granted packet for the crossbar.
module input_port_buffer
    import packet_pkg::*;
#(
    parameter int DEPTH   = 4,
    parameter int PORT_ID = 0
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  in_valid,
    input  logic [PKT_WIDTH-1:0]  in_pkt,
    output logic                  in_ready,
    output logic                  port_req,
    output logic [ADDR_WIDTH-1:0] port_dst,
    input  logic                  grant,
    output logic                  out_valid,
    output logic [PKT_WIDTH-1:0]  out_pkt,
    output logic [1:0]            out_src,
    output logic [7:0]            drop_cnt,
    output logic                  err_spur_grant
);
    packet_t              in_p, head_p;
    logic [PKT_WIDTH-1:0] head_raw;
    logic                 fifo_full, fifo_empty;
    logic                 accept, drop, push, pop, spur;

    logic                 out_valid_q, out_valid_d;
    logic [PKT_WIDTH-1:0] out_pkt_q, out_pkt_d;
    logic [7:0]           drop_cnt_q, drop_cnt_d;
    logic                 err_spur_q, err_spur_d;

    assign in_p   = packet_t'(in_pkt);
    assign head_p = packet_t'(head_raw);

    // in_ready looks only at occupancy, so a same-cycle pop never frees a full slot.
    assign in_ready = !fifo_full;
    assign accept   = in_valid && in_ready;
    assign drop     = accept && (in_p.dst_mask == '0);
    assign push     = accept && !drop;
    assign pop      = grant && !fifo_empty;
    assign spur     = grant && fifo_empty;

    sync_fifo #(
        .WIDTH (PKT_WIDTH),
        .DEPTH (DEPTH)
    ) u_fifo (
        .clk     (clk),
        .rst_n   (rst_n),
        .wr_en   (push),
        .wr_data (in_pkt),
        .rd_en   (pop),
        .rd_data (head_raw),
        .full    (fifo_full),
        .empty   (fifo_empty)
    );

    assign port_req = !fifo_empty;
    assign port_dst = fifo_empty ? '0 : head_p.dst_mask;

    always_comb begin
        out_valid_d = pop;
        out_pkt_d   = pop ? head_raw : out_pkt_q;
        drop_cnt_d  = drop_cnt_q;
        if (drop && (drop_cnt_q != 8'hFF)) begin
            drop_cnt_d = drop_cnt_q + 8'd1;
        end
        err_spur_d  = err_spur_q || spur;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            out_valid_q <= 1'b0;
            out_pkt_q   <= '0;
            drop_cnt_q  <= '0;
            err_spur_q  <= 1'b0;
        end else begin
            out_valid_q <= out_valid_d;
            out_pkt_q   <= out_pkt_d;
            drop_cnt_q  <= drop_cnt_d;
            err_spur_q  <= err_spur_d;
        end
    end

    assign out_valid      = out_valid_q;
    assign out_pkt        = out_pkt_q;
    assign out_src        = 2'(PORT_ID);
    assign drop_cnt       = drop_cnt_q;
    assign err_spur_grant = err_spur_q;
endmodule

// File: tb/tb_input_port_buffer.sv
// Directed bench for input_port_buffer: inputs change and outputs are sampled on the falling edge.
module tb_input_port_buffer;
    localparam int PORT_ID = 2;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        in_valid;
    logic [15:0] in_pkt;
    logic        in_ready;
    logic        port_req;
    logic [3:0]  port_dst;
    logic        grant;
    logic        out_valid;
    logic [15:0] out_pkt;
    logic [1:0]  out_src;
    logic [7:0]  drop_cnt;
    logic        err_spur_grant;

    int checks = 0;
    int errors = 0;

    always #5 clk = ~clk;

    input_port_buffer #(.DEPTH(4), .PORT_ID(PORT_ID)) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .in_valid       (in_valid),
        .in_pkt         (in_pkt),
        .in_ready       (in_ready),
        .port_req       (port_req),
        .port_dst       (port_dst),
        .grant          (grant),
        .out_valid      (out_valid),
        .out_pkt        (out_pkt),
        .out_src        (out_src),
        .drop_cnt       (drop_cnt),
        .err_spur_grant (err_spur_grant)
    );

    task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h want %0h", tag, act, exp);
        end
    endtask

    task automatic cyc();
        @(negedge clk);
    endtask

    logic [15:0] fill_pkts [4];
    logic [15:0] sb [$];
    logic [15:0] pkt, exp_pkt;

    initial begin
        fill_pkts[0] = 16'h1001;
        fill_pkts[1] = 16'h2102;
        fill_pkts[2] = 16'h4203;
        fill_pkts[3] = 16'hA304;
        rst_n    = 1'b1;
        in_valid = 1'b0;
        in_pkt   = '0;
        grant    = 1'b0;
        #2 rst_n = 1'b0;
        #1;
        chk("rst_out_valid", 32'(out_valid), 0);
        chk("rst_out_pkt", 32'(out_pkt), 0);
        chk("rst_drop_cnt", 32'(drop_cnt), 0);
        chk("rst_err", 32'(err_spur_grant), 0);
        repeat (2) cyc();
        rst_n = 1'b1;
        cyc();
        chk("post_rst_req", 32'(port_req), 0);
        chk("post_rst_dst", 32'(port_dst), 0);
        chk("post_rst_ready", 32'(in_ready), 1);
        chk("out_src", 32'(out_src), PORT_ID);

        // Single packet through
        in_valid = 1'b1; in_pkt = 16'h1A55;
        cyc();
        in_valid = 1'b0;
        chk("single_req", 32'(port_req), 1);
        chk("single_dst", 32'(port_dst), 32'h1);
        grant = 1'b1;
        cyc();
        grant = 1'b0;
        chk("single_ovalid", 32'(out_valid), 1);
        chk("single_opkt", 32'(out_pkt), 32'h1A55);
        chk("single_req_after", 32'(port_req), 0);
        cyc();
        chk("single_ovalid_pulse", 32'(out_valid), 0);
        chk("single_opkt_hold", 32'(out_pkt), 32'h1A55);

        // Fill to full, reject a fifth, then drain back-to-back
        for (int i = 0; i < 4; i++) begin
            chk("fill_ready", 32'(in_ready), 1);
            in_valid = 1'b1; in_pkt = fill_pkts[i];
            cyc();
        end
        in_valid = 1'b0;
        chk("full_ready", 32'(in_ready), 0);
        in_valid = 1'b1; in_pkt = 16'hF0FF;
        cyc();
        in_valid = 1'b0;
        chk("full_ready_hold", 32'(in_ready), 0);
        chk("full_head_dst", 32'(port_dst), 32'h1);
        for (int i = 0; i < 4; i++) begin
            grant = 1'b1;
            cyc();
            chk("drain_ovalid", 32'(out_valid), 1);
            chk("drain_opkt", 32'(out_pkt), 32'(fill_pkts[i]));
        end
        grant = 1'b0;
        chk("drain_empty_req", 32'(port_req), 0);
        chk("drain_empty_ready", 32'(in_ready), 1);
        cyc();
        chk("drain_ovalid_low", 32'(out_valid), 0);
        chk("drain_no_spur", 32'(err_spur_grant), 0);

        // Zero-destination drop and counter saturation
        in_valid = 1'b1; in_pkt = 16'h0123;
        chk("drop_ready", 32'(in_ready), 1);
        cyc();
        in_valid = 1'b0;
        chk("drop_no_req", 32'(port_req), 0);
        chk("drop_cnt1", 32'(drop_cnt), 1);
        in_valid = 1'b1; in_pkt = 16'h0ABC;
        repeat (300) cyc();
        chk("drop_sat", 32'(drop_cnt), 255);
        cyc();
        in_valid = 1'b0;
        chk("drop_sat_hold", 32'(drop_cnt), 255);
        chk("drop_sat_no_req", 32'(port_req), 0);

        // Simultaneous push/pop at occupancy 2, across pointer wraps
        sb.delete();
        for (int i = 0; i < 2; i++) begin
            pkt = {4'b0001 << i, 4'h5, 8'(8'hE0 + i)};
            in_valid = 1'b1; in_pkt = pkt;
            sb.push_back(pkt);
            cyc();
        end
        for (int k = 0; k < 10; k++) begin
            pkt = {4'b0001 << (k % 4), 4'h3, 8'(k)};
            in_valid = 1'b1; in_pkt = pkt; grant = 1'b1;
            exp_pkt = sb.pop_front();
            sb.push_back(pkt);
            cyc();
            chk("simul_ovalid", 32'(out_valid), 1);
            chk("simul_opkt", 32'(out_pkt), 32'(exp_pkt));
            chk("simul_req", 32'(port_req), 1);
            chk("simul_ready", 32'(in_ready), 1);
        end
        in_valid = 1'b0;
        for (int i = 0; i < 2; i++) begin
            exp_pkt = sb.pop_front();
            grant = 1'b1;
            cyc();
            chk("simul_tail_opkt", 32'(out_pkt), 32'(exp_pkt));
        end
        grant = 1'b0;
        chk("simul_empty", 32'(port_req), 0);

        // Spurious grant while empty
        cyc();
        grant = 1'b1;
        cyc();
        grant = 1'b0;
        chk("spur_ovalid", 32'(out_valid), 0);
        chk("spur_err", 32'(err_spur_grant), 1);
        chk("spur_empty", 32'(port_req), 0);
        repeat (2) cyc();
        chk("spur_sticky", 32'(err_spur_grant), 1);

        // Asynchronous reset mid-stream
        for (int i = 0; i < 3; i++) begin
            in_valid = 1'b1; in_pkt = fill_pkts[i];
            cyc();
        end
        in_valid = 1'b0; grant = 1'b1;
        cyc();
        grant = 1'b0;
        chk("pre_rst_ovalid", 32'(out_valid), 1);
        chk("pre_rst_req", 32'(port_req), 1);
        #2 rst_n = 1'b0;
        #1;
        chk("mid_rst_req", 32'(port_req), 0);
        chk("mid_rst_ovalid", 32'(out_valid), 0);
        chk("mid_rst_drop", 32'(drop_cnt), 0);
        chk("mid_rst_err", 32'(err_spur_grant), 0);
        chk("mid_rst_opkt", 32'(out_pkt), 0);
        cyc();
        rst_n = 1'b1;
        cyc();
        chk("rel_ready", 32'(in_ready), 1);
        chk("rel_req", 32'(port_req), 0);
        chk("rel_dst", 32'(port_dst), 0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule

// File: doc/input_port_buffer.md
Name: input_port_buffer

Overview:
- Per-port ingress stage that sits directly upstream of the switch arbiter; the switch instantiates four of them.
- Accepts packets over a valid/ready handshake and queues them in a small FIFO.
- Presents the head packet's request and one-hot destination mask to the arbiter.
- On grant, pops the head into a one-cycle output register, aligned with the arbiter's registered mux_sel/active, for the crossbar to consume.

Parameters:
- DEPTH, 4, FIFO entries; power of two, minimum 2.
- PORT_ID, 0, index of this port (0..NUM_PORTS-1); stamped into the output sideband.

Ports:
- clk  in  1  switch clock.
- rst_n  in  1  asynchronous, active-low reset.
- in_valid  in  1  ingress packet valid.
- in_pkt  in  PKT_WIDTH  ingress packet (packet_t).
- in_ready  out  1  buffer can accept this cycle.
- port_req  out  1  head packet pending; feeds arbiter port_reqs[PORT_ID].
- port_dst  out  ADDR_WIDTH  head destination mask; all zeros when empty.
- grant  in  1  arbiter grant_bus[PORT_ID], same-cycle combinational.
- out_valid  out  1  granted packet on out_pkt this cycle.
- out_pkt  out  PKT_WIDTH  granted packet, to crossbar data mux.
- out_src  out  2  PORT_ID constant, valid with out_valid.
- drop_cnt  out  8  saturating count of dropped packets.
- err_spur_grant  out  1  sticky: grant seen while port_req=0.

Behaviour:
- Clock and reset:
  - Single clock clk; reset rst_n is asynchronous, active-low.
  - On reset: FIFO empty, rd/wr pointers 0, out_valid=0, out_pkt=0, drop_cnt=0, err_spur_grant=0.
  - After reset: port_req=0, port_dst=0, in_ready=1.
- Packet format (packet_t, 16 bits): [15:12] dst_mask (one-hot or multicast), [11:10] src, [9:8] type, [7:0] payload.
- Ingress:
  - Transfer occurs when in_valid && in_ready.
  - in_ready = !full, combinational from state only; it never depends on grant.
  - When full, a push is not accepted even if a pop occurs in the same cycle.
- Drop rule:
  - An accepted packet with dst_mask==0 is not written to the FIFO.
  - drop_cnt increments, saturating at 255.
  - in_ready still reads 1 for that transfer.
- Head presentation:
  - port_req = !empty.
  - port_dst = head dst_mask when non-empty, else 0.
  - Both are driven from registered state only (FIFO storage plus pointers), never from in_* in the same cycle.
  - Latency: a packet accepted at edge N drives port_req at cycle N+1 when the FIFO was empty.
- Pop:
  - At a rising edge with grant && port_req: out_pkt <= head, out_valid <= 1, read pointer advances.
  - Otherwise out_valid <= 0 and out_pkt holds its value.
  - out_valid is high for exactly one cycle per grant.
  - Consecutive grants pop consecutive entries back-to-back at one per cycle.
- Simultaneous push and pop when not full: both occur and occupancy is unchanged.
- Empty case: a grant with port_req=0 is ignored (no pop, out_valid=0) and sets err_spur_grant, which is cleared only by reset.
- Pointers: log2(DEPTH)+1 bits wide, with the extra wrap bit distinguishing full from empty.
  - full = addresses equal and wrap bits differ.
  - empty = pointers fully equal.
  - Pointers wrap modulo 2*DEPTH.
- Ordering: strict FIFO; there is no head-of-line bypass.
- Reset mid-operation: queued packets are discarded and the next cycle shows port_req=0.

Decomposition:
- Package packet_pkg holds:
  - NUM_PORTS=4, ADDR_WIDTH=4, PKT_WIDTH=16.
  - packet_t as a packed struct with fields dst_mask, src, type, payload.
- Sub-module sync_fifo (parameters WIDTH, DEPTH):
  - Storage, pointers, full/empty.
  - Combinational head read.
- input_port_buffer wraps sync_fifo and adds:
  - Drop filter.
  - Output register.
  - Counters and error flag.

Test Plan:
- Single packet: push 16'h1A55 (dst 0001) into an empty buffer → port_req=1 and port_dst=4'b0001 next cycle; grant held 1 cycle → out_valid=1 with out_pkt=16'h1A55 on the following cycle, then port_req=0.
- Fill/full: push 4 packets with no grant → in_ready=0 after the 4th; a 5th in_valid is not accepted; grant 4 consecutive cycles → packets emerge in order, 4 out_valid pulses, then empty.
- Drop: push 16'h0123 (dst 0000) → no port_req, drop_cnt=1; push 300 zero-dst packets → drop_cnt=255 and holds.
- Simultaneous: with 2 entries, push and grant in the same cycle → occupancy stays 2, pop returns the oldest entry; repeat across the 2*DEPTH pointer wrap with no corruption.
- Spurious grant: grant=1 while empty → out_valid=0, err_spur_grant=1 and sticky; FIFO remains empty.
- Reset mid-stream: 3 queued, assert rst_n=0 asynchronously mid-cycle → port_req, out_valid, drop_cnt all 0 immediately; after release in_ready=1.
